// File: rtl/phys_free_list_if.sv
// Rename/retire side of the physical-register free list.
// Master: rename + retire logic driving requests and retired tags.
// Slave: the free list, returning grant, tags and occupancy.
interface phys_free_list_if #(
  parameter int PHY_WIDTH = 6
);
  logic                 flush;
  logic                 alloc_req_0;
  logic                 alloc_req_1;
  logic                 alloc_ready;
  logic [PHY_WIDTH-1:0] alloc_tag_0;
  logic [PHY_WIDTH-1:0] alloc_tag_1;
  logic                 retire_valid_0;
  logic [4:0]           retire_rd_arch_0;
  logic [PHY_WIDTH-1:0] retire_phy_old_0;
  logic                 retire_valid_1;
  logic [4:0]           retire_rd_arch_1;
  logic [PHY_WIDTH-1:0] retire_phy_old_1;
  logic [PHY_WIDTH:0]   free_count;

  modport master (
    output flush, alloc_req_0, alloc_req_1,
    output retire_valid_0, retire_rd_arch_0, retire_phy_old_0,
    output retire_valid_1, retire_rd_arch_1, retire_phy_old_1,
    input  alloc_ready, alloc_tag_0, alloc_tag_1, free_count
  );

  modport slave (
    input  flush, alloc_req_0, alloc_req_1,
    input  retire_valid_0, retire_rd_arch_0, retire_phy_old_0,
    input  retire_valid_1, retire_rd_arch_1, retire_phy_old_1,
    output alloc_ready, alloc_tag_0, alloc_tag_1, free_count
  );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical tags: two grants to rename, two reclaims from retire.
// Latency: grant and tags are combinational from state; frees become visible next cycle.
// Backpressure: alloc_ready drops when fewer free tags than requested; no partial grant.
module phys_free_list #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = 6
) (
  input logic            clk,
  input logic            rst_n,
  phys_free_list_if.slave fl
);

  localparam int                   FREE_REGS = PHY_REGS - ARCH_REGS;
  localparam logic [PHY_WIDTH:0]   FREE_CNT  = (PHY_WIDTH+1)'(FREE_REGS);
  localparam logic [PHY_WIDTH-1:0] TAIL_RST  = PHY_WIDTH'(FREE_REGS);

  logic [PHY_WIDTH-1:0] mem [PHY_REGS];
  logic [PHY_WIDTH-1:0] head;
  logic [PHY_WIDTH-1:0] tail;
  logic [PHY_WIDTH-1:0] arch_head;
  logic [PHY_WIDTH:0]   count;

  logic [1:0]           n_req;
  logic [1:0]           n_free;
  logic [1:0]           n_alloc;
  logic                 free_0;
  logic                 free_1;
  logic                 ready;
  logic [PHY_WIDTH-1:0] tail_1;
  logic [PHY_WIDTH+1:0] count_sum;

  // Grant decision, retire qualification and next occupancy
  always_comb begin
    n_req     = {1'b0, fl.alloc_req_0} + {1'b0, fl.alloc_req_1};
    // rd_arch 0 never held a renamed tag, so nothing is reclaimed for it
    free_0    = fl.retire_valid_0 && (fl.retire_rd_arch_0 != 5'd0) && !fl.flush;
    free_1    = fl.retire_valid_1 && (fl.retire_rd_arch_1 != 5'd0) && !fl.flush;
    n_free    = {1'b0, free_0} + {1'b0, free_1};
    ready     = (count >= {{(PHY_WIDTH-1){1'b0}}, n_req});
    n_alloc   = (ready && !fl.flush) ? n_req : 2'd0;
    // Packet 1 lands behind packet 0 only when packet 0 also frees
    tail_1    = free_0 ? tail + PHY_WIDTH'(1) : tail;
    // One extra bit so an over-free is visible instead of wrapping
    count_sum = {1'b0, count} + {{PHY_WIDTH{1'b0}}, n_free} - {{PHY_WIDTH{1'b0}}, n_alloc};
  end

  assign fl.alloc_ready = ready;
  assign fl.alloc_tag_0 = mem[head];
  assign fl.alloc_tag_1 = mem[head + PHY_WIDTH'(1)];
  assign fl.free_count  = count;

  // Pointer and occupancy state; flush rewinds speculative allocations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= TAIL_RST;
      arch_head <= '0;
      count     <= FREE_CNT;
    end else if (fl.flush) begin
      head  <= arch_head;
      count <= FREE_CNT;
    end else begin
      head      <= head + PHY_WIDTH'(n_alloc);
      tail      <= tail + PHY_WIDTH'(n_free);
      arch_head <= arch_head + PHY_WIDTH'(n_free);
      count     <= count_sum[PHY_WIDTH:0];
    end
  end

  // Tag storage; reset seeds the tags not used by the initial architectural mapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PHY_REGS; k++) begin
        mem[k] <= (k < FREE_REGS) ? PHY_WIDTH'(ARCH_REGS + k) : '0;
      end
    end else begin
      if (free_0) mem[tail]   <= fl.retire_phy_old_0;
      if (free_1) mem[tail_1] <= fl.retire_phy_old_1;
    end
  end

  // Retiring more tags than were ever handed out corrupts the list
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    count_sum <= {1'b0, FREE_CNT});

  // Committed region always spans exactly the free-tag budget
  a_tail_gap: assert property (@(posedge clk) disable iff (!rst_n)
    (tail - arch_head) == TAIL_RST);

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;
  localparam int PHY_REGS  = 64;
  localparam int ARCH_REGS = 32;
  localparam int PHY_WIDTH = 6;
  localparam int FREE_REGS = PHY_REGS - ARCH_REGS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phys_free_list_if #(.PHY_WIDTH(PHY_WIDTH)) fl();

  phys_free_list #(
    .PHY_REGS (PHY_REGS),
    .ARCH_REGS(ARCH_REGS),
    .PHY_WIDTH(PHY_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fl   (fl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: free tags in hand-out order, and handed-out tags not yet committed
  int free_q[$];
  int inflight_q[$];
  // Stimulus helper: current committed mapping, used to pick realistic phy_old
  int arch_map[ARCH_REGS];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    inflight_q.delete();
    for (int k = ARCH_REGS; k < PHY_REGS; k++) free_q.push_back(k);
    for (int r = 0; r < ARCH_REGS; r++) arch_map[r] = r;
  endtask

  // Outputs vs. reference, taken mid-cycle with this cycle's inputs applied
  task automatic check_model();
    int nreq;
    logic [PHY_WIDTH-1:0] gap;
    nreq = int'(fl.alloc_req_0) + int'(fl.alloc_req_1);
    check("free_count", int'(fl.free_count), free_q.size());
    check("alloc_ready", int'(fl.alloc_ready), int'(free_q.size() >= nreq));
    if (free_q.size() >= 1) check("alloc_tag_0", int'(fl.alloc_tag_0), free_q[0]);
    if (free_q.size() >= 2) check("alloc_tag_1", int'(fl.alloc_tag_1), free_q[1]);
    gap = dut.tail - dut.arch_head;
    check("tail_arch_gap", int'(gap), FREE_REGS);
  endtask

  // Apply the rules of one clock edge to the reference
  task automatic model_step();
    int nreq;
    if (fl.flush) begin
      while (inflight_q.size() > 0) free_q.push_front(inflight_q.pop_back());
    end else begin
      nreq = int'(fl.alloc_req_0) + int'(fl.alloc_req_1);
      if (free_q.size() >= nreq)
        repeat (nreq) inflight_q.push_back(free_q.pop_front());
      if (fl.retire_valid_0 && fl.retire_rd_arch_0 != 0) begin
        void'(inflight_q.pop_front());
        free_q.push_back(int'(fl.retire_phy_old_0));
      end
      if (fl.retire_valid_1 && fl.retire_rd_arch_1 != 0) begin
        void'(inflight_q.pop_front());
        free_q.push_back(int'(fl.retire_phy_old_1));
      end
    end
  endtask

  task automatic drive(input logic r0, input logic r1,
                       input logic v0, input int a0, input int p0,
                       input logic v1, input int a1, input int p1,
                       input logic f);
    fl.alloc_req_0      = r0;
    fl.alloc_req_1      = r1;
    fl.retire_valid_0   = v0;
    fl.retire_rd_arch_0 = 5'(a0);
    fl.retire_phy_old_0 = PHY_WIDTH'(p0);
    fl.retire_valid_1   = v1;
    fl.retire_rd_arch_1 = 5'(a1);
    fl.retire_phy_old_1 = PHY_WIDTH'(p1);
    fl.flush            = f;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic to_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_pos();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random cycle: legal protocol, retires only commit tags actually handed out
  task automatic gen_random(input int alloc_bias);
    int   nreq, nf;
    logic f;
    logic v [2];
    int   rd [2];
    int   ph [2];
    nreq = ($urandom_range(0, 99) < alloc_bias) ? int'($urandom_range(1, 2)) : 0;
    f    = ($urandom_range(0, 49) == 0);
    nf   = 0;
    for (int p = 0; p < 2; p++) begin
      v[p]  = ($urandom_range(0, 99) < (100 - alloc_bias));
      rd[p] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, ARCH_REGS - 1));
      ph[p] = int'($urandom_range(0, PHY_REGS - 1));
      if (v[p] && rd[p] != 0 && !f) begin
        if (nf < inflight_q.size()) begin
          ph[p] = arch_map[rd[p]];
          arch_map[rd[p]] = inflight_q[nf];
          nf++;
        end else begin
          v[p] = 1'b0;
        end
      end
    end
    drive(nreq >= 1, nreq == 2, v[0], rd[0], ph[0], v[1], rd[1], ph[1], f);
  endtask

  initial begin
    do_reset();

    // Reset state and single-wide allocation
    to_neg();
    check("rst_free_count", int'(fl.free_count), 32);
    check("rst_alloc_ready", int'(fl.alloc_ready), 1);
    check("rst_tag_0", int'(fl.alloc_tag_0), 32);
    check("rst_tag_1", int'(fl.alloc_tag_1), 33);
    to_pos();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      to_neg();
      check("single_tag", int'(fl.alloc_tag_0), 32 + i);
      check("single_ready", int'(fl.alloc_ready), 1);
      to_pos();
    end
    idle();
    to_neg();
    check("single_count", int'(fl.free_count), 29);
    to_pos();

    // Dual allocation down to empty
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      to_neg();
      if (i == 15) begin
        check("dual_last_tag_0", int'(fl.alloc_tag_0), 62);
        check("dual_last_tag_1", int'(fl.alloc_tag_1), 63);
      end
      to_pos();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg();
    check("empty_count", int'(fl.free_count), 0);
    check("empty_ready", int'(fl.alloc_ready), 0);
    to_pos();
    idle();
    to_neg();
    check("empty_head_hold", int'(dut.head), 32);
    to_pos();

    // No partial grant; same-cycle free visible only next cycle
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      to_pos();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    to_pos();
    drive(1, 1, 1, 3, 5, 0, 0, 0, 0);
    to_neg();
    check("partial_count", int'(fl.free_count), 1);
    check("partial_ready", int'(fl.alloc_ready), 0);
    to_pos();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    to_neg();
    check("reclaim_count", int'(fl.free_count), 2);
    check("reclaim_ready", int'(fl.alloc_ready), 1);
    check("reclaim_tag_0", int'(fl.alloc_tag_0), 63);
    check("reclaim_tag_1", int'(fl.alloc_tag_1), 5);
    to_pos();

    // Allocate 10, retire 4, flush rewinds to committed point
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      to_pos();
    end
    drive(0, 0, 1, 1, 1, 1, 2, 2, 0);
    cyc();
    drive(0, 0, 1, 3, 3, 1, 4, 4, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg();
    check("flush_count", int'(fl.free_count), 32);
    check("flush_tag_0", int'(fl.alloc_tag_0), 36);
    to_pos();

    // rd_arch 0 reclaims nothing; packet 1 alone lands at tail
    drive(0, 0, 1, 0, 9, 1, 5, 7, 0);
    to_neg();
    check("zero_arch_before", int'(fl.free_count), 31);
    to_pos();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    to_neg();
    check("zero_arch_after", int'(fl.free_count), 32);
    check("post_zero_tag_0", int'(fl.alloc_tag_0), 37);
    check("post_zero_tag_1", int'(fl.alloc_tag_1), 38);
    to_pos();

    // Flush beats both allocation and retirement
    drive(1, 1, 1, 6, 6, 1, 7, 7, 1);
    cyc();
    idle();
    to_neg();
    check("flush_prio_count", int'(fl.free_count), 32);
    check("flush_prio_tag_0", int'(fl.alloc_tag_0), 37);
    to_pos();

    // Randomized traffic, allocation heavy then retirement heavy
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      gen_random(70);
      cyc();
    end

    // Asynchronous reset in the middle of traffic
    gen_random(70);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_count", int'(fl.free_count), 32);
    check("async_rst_tag_0", int'(fl.alloc_tag_0), 32);
    check("async_rst_tag_1", int'(fl.alloc_tag_1), 33);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      gen_random(($urandom_range(0, 1) == 1) ? 40 : 60);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
